// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
// overflow/underflow error pulses and optional first-word-fall-through read.
module sync_fifo_flags #(
  parameter int FIFO_DEPTH       = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 2,
  parameter int FWFT             = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LVL);

  // Reject illegal parameter combinations at elaboration.
  if (!(FIFO_DEPTH >= 2 && (FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0 &&
        ALMOST_EMPTY_LVL >= 0 && ALMOST_EMPTY_LVL < ALMOST_FULL_LVL &&
        ALMOST_FULL_LVL <= FIFO_DEPTH && (FWFT == 0 || FWFT == 1))) begin : g_param_check
    $error("sync_fifo_flags: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CW-1:0]         count_nxt;

  // Acceptance decisions use the registered flags from before the edge.
  always_comb begin
    wr_acc    = cs & wr_en & ~full;
    rd_acc    = cs & rd_en & ~empty;
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end

  // Storage array; not reset so contents survive only as data, never state.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, count, flags and error pulses; flags come from next-count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == DEPTH_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
      overflow     <= cs & wr_en & full;
      underflow    <= cs & rd_en & empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is presented directly; zero while nothing is stored.
    always_comb begin
      data_out = empty ? '0 : mem[rd_ptr];
    end
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_q;

    // Registered read: capture the head entry on an accepted read only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         rd_q <= '0;
      else if (rd_acc) rd_q <= mem[rd_ptr];
    end

    // Expose the read register.
    always_comb begin
      data_out = rd_q;
    end
  end

endmodule
